// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the pipeline control path: jump/branch types,
// next-PC mux selects and 2-bit predictor counter states.
package riscv_ctrl_pkg;

    // ex_j_type encodings
    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] JAL    = 2'b01;
    localparam logic [1:0] JAL_R  = 2'b10;
    localparam logic [1:0] BRANCH = 2'b11;

    // ex_branch_t encodings
    localparam logic [1:0] BEQ = 2'b00;
    localparam logic [1:0] BNE = 2'b01;
    localparam logic [1:0] BLT = 2'b10;
    localparam logic [1:0] BGE = 2'b11;

    // pc_sel encodings
    localparam logic [1:0] PCS_SEQ   = 2'b00;  // PC+4
    localparam logic [1:0] PCS_ID    = 2'b01;  // ID branch target
    localparam logic [1:0] PCS_EX    = 2'b10;  // EX target
    localparam logic [1:0] PCS_EXSEQ = 2'b11;  // EX PC+4

    // 2-bit saturating counter states
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating step of a 2-bit counter towards taken (up) or not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        nxt = cur;
        if (up && cur != CTR_ST)
            nxt = cur + 2'd1;
        else if (!up && cur != CTR_SNT)
            nxt = cur - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Branch history table: 2^IDX_W two-bit saturating counters, one async
// read port and one saturating inc/dec write port. Reads see the old value
// when the write index matches (the write lands at the edge).
module bp_table
    import riscv_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_up_i
);

    localparam int NENT = 1 << IDX_W;

    logic [NENT-1:0][1:0] tbl_q;

    assign rd_ctr_o = tbl_q[rd_idx_i];

    // Counter array: all entries weakly not-taken out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++)
                tbl_q[i] <= CTR_WNT;
        end else if (wr_en_i) begin
            tbl_q[wr_idx_i] <= ctr_step(tbl_q[wr_idx_i], wr_up_i);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// gshare branch predictor and redirect controller. Predicts in ID, resolves
// in EX, drives the next-PC select and IF/ID, ID/EX flushes, and counts
// resolved branches and mispredictions.
module branch_predict_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [XLEN-1:0]  id_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [1:0]       ex_j_type,
    input  logic [1:0]       ex_branch_t,
    input  logic             ex_zero,
    input  logic             ex_sign,
    output logic [1:0]       pc_sel,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [IDX_W-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pred_q, pred_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] id_idx;
    logic [1:0]       rd_ctr;
    logic             act;
    logic             upd;

    logic sig_unused;
    assign sig_unused = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0]};

    assign id_idx     = id_pc[IDX_W+1:2] ^ ghr_q;
    assign pred_taken = id_valid & id_is_branch & rd_ctr[1];
    assign upd        = ex_valid & (ex_j_type == BRANCH) & br_q & ~stall;

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mis_cnt_q;

    bp_table #(.IDX_W(IDX_W)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx_i (id_idx),
        .rd_ctr_o (rd_ctr),
        .wr_en_i  (upd),
        .wr_idx_i (idx_q),
        .wr_up_i  (act)
    );

    // Actual branch outcome from the EX compare flags.
    always_comb begin
        act = 1'b0;
        case (ex_branch_t)
            BEQ: act = ex_zero;
            BNE: act = ~ex_zero;
            BLT: act = ex_sign;
            BGE: act = ~ex_sign;
            default: act = 1'b0;
        endcase
    end

    // Redirect priority: EX jump/mispredict beats an ID predicted-taken.
    always_comb begin
        pc_sel      = PCS_SEQ;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst_n && !stall) begin
            if (ex_valid && (ex_j_type == JAL || ex_j_type == JAL_R)) begin
                pc_sel      = PCS_EX;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (ex_valid && ex_j_type == BRANCH && act && !pred_q) begin
                pc_sel      = PCS_EX;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (ex_valid && ex_j_type == BRANCH && !act && pred_q) begin
                pc_sel      = PCS_EXSEQ;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (pred_taken) begin
                pc_sel      = PCS_ID;
                flush_if_id = 1'b1;
            end
        end
    end

    // Next state for GHR, ID->EX tracking and perf counters.
    always_comb begin
        ghr_d     = ghr_q;
        idx_d     = idx_q;
        pred_d    = pred_q;
        br_d      = br_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (!stall) begin
            if (flush_id_ex) begin
                idx_d  = '0;
                pred_d = 1'b0;
                br_d   = 1'b0;
            end else begin
                idx_d  = id_idx;
                pred_d = pred_taken;
                br_d   = id_valid & id_is_branch;
            end
        end
        if (upd) begin
            ghr_d = {ghr_q[IDX_W-2:0], act};
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + 1'b1;
            if (act != pred_q && mis_cnt_q != '1)
                mis_cnt_d = mis_cnt_q + 1'b1;
        end
        if (perf_clr) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q     <= '0;
            idx_q     <= '0;
            pred_q    <= 1'b0;
            br_q      <= 1'b0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            idx_q     <= idx_d;
            pred_q    <= pred_d;
            br_q      <= br_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_predict_ctrl;

    localparam int IDX_W = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int NENT  = 1 << IDX_W;

    logic             clk, rst_n, stall;
    logic             id_valid, id_is_branch;
    logic [XLEN-1:0]  id_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [1:0]       ex_j_type, ex_branch_t;
    logic             ex_zero, ex_sign;
    logic [1:0]       pc_sel;
    logic             flush_if_id, flush_id_ex;
    logic             perf_clr;
    logic [CNT_W-1:0] br_cnt, mispred_cnt;

    branch_predict_ctrl #(.IDX_W(IDX_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc),
        .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_j_type(ex_j_type), .ex_branch_t(ex_branch_t),
        .ex_zero(ex_zero), .ex_sign(ex_sign),
        .pc_sel(pc_sel), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .perf_clr(perf_clr), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int bht [NENT];
    int ghr, m_idx, m_pred, m_br, m_brc, m_mis;
    // Model combinational results for the current cycle
    int e_idx, e_pt, e_act, e_sel, e_fi, e_fd;

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) bht[i] = 1;
        ghr = 0; m_idx = 0; m_pred = 0; m_br = 0; m_brc = 0; m_mis = 0;
    endtask

    task automatic model_eval();
        bit is_jump, is_br;
        e_idx = ((id_pc >> 2) % NENT) ^ ghr;
        e_pt  = (id_valid && id_is_branch && bht[e_idx] >= 2) ? 1 : 0;
        case (ex_branch_t)
            2'd0: e_act = ex_zero;
            2'd1: e_act = !ex_zero;
            2'd2: e_act = ex_sign;
            default: e_act = !ex_sign;
        endcase
        is_jump = ex_valid && (ex_j_type == 2'd1 || ex_j_type == 2'd2);
        is_br   = ex_valid && ex_j_type == 2'd3;
        e_sel = 0; e_fi = 0; e_fd = 0;
        if (!rst_n || stall) begin
            e_sel = 0;
        end else if (is_jump || (is_br && e_act == 1 && m_pred == 0)) begin
            e_sel = 2; e_fi = 1; e_fd = 1;
        end else if (is_br && e_act == 0 && m_pred == 1) begin
            e_sel = 3; e_fi = 1; e_fd = 1;
        end else if (e_pt == 1) begin
            e_sel = 1; e_fi = 1;
        end
    endtask

    task automatic model_edge();
        if (!stall) begin
            if (ex_valid && ex_j_type == 2'd3 && m_br == 1) begin
                bht[m_idx] = e_act ? ((bht[m_idx] < 3) ? bht[m_idx] + 1 : 3)
                                   : ((bht[m_idx] > 0) ? bht[m_idx] - 1 : 0);
                ghr = ((ghr * 2) + e_act) % NENT;
                if (m_brc < CMAX) m_brc++;
                if (e_act != m_pred && m_mis < CMAX) m_mis++;
            end
            if (e_fd == 1) begin
                m_idx = 0; m_pred = 0; m_br = 0;
            end else begin
                m_idx = e_idx; m_pred = e_pt; m_br = (id_valid && id_is_branch) ? 1 : 0;
            end
        end
        if (perf_clr) begin
            m_brc = 0; m_mis = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input bit isb, input logic [XLEN-1:0] pc,
                          input bit exv, input logic [1:0] jt, input logic [1:0] bt,
                          input bit z, input bit s, input bit st, input bit clr);
        id_valid = v; id_is_branch = isb; id_pc = pc;
        ex_valid = exv; ex_j_type = jt; ex_branch_t = bt;
        ex_zero = z; ex_sign = s; stall = st; perf_clr = clr;
    endtask

    // Inputs are set just after a falling edge; evaluate and compare.
    task automatic step_pre();
        #1;
        if (!rst_n) model_reset();
        model_eval();
        chk("pred_taken", pred_taken, e_pt);
        chk("pc_sel", pc_sel, e_sel);
        chk("flush_if_id", flush_if_id, e_fi);
        chk("flush_id_ex", flush_id_ex, e_fd);
        chk("br_cnt", br_cnt, m_brc);
        chk("mispred_cnt", mispred_cnt, m_mis);
    endtask

    task automatic step_post();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1, 1, 32'h40, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        // Reset values
        step_pre();
        chk("rst pred_taken", pred_taken, 0);
        chk("rst pc_sel", pc_sel, 0);
        chk("rst br_cnt", br_cnt, 0);
        chk("rst mispred_cnt", mispred_cnt, 0);
        step_post();
        rst_n = 1'b1;

        // A: BEQ at 0x40 in ID, index 0, predicted not-taken
        set_in(1, 1, 32'h40, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre(); chk("A pred", pred_taken, 0); chk("A sel", pc_sel, 0); step_post();
        // B: resolves taken -> mispredict to EX target
        set_in(0, 0, 32'h0, 1, 2'd3, 2'd0, 1, 0, 0, 0);
        step_pre(); chk("B sel", pc_sel, 2); chk("B fi", flush_if_id, 1); chk("B fd", flush_id_ex, 1); step_post();
        // C: ID at 0x44 -> index 1^1=0, counter now WT -> predicted taken
        set_in(1, 1, 32'h44, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre();
        chk("C br_cnt", br_cnt, 1); chk("C mis", mispred_cnt, 1);
        chk("C pred", pred_taken, 1); chk("C sel", pc_sel, 1);
        chk("C fi", flush_if_id, 1); chk("C fd", flush_id_ex, 0);
        step_post();
        // D: BNE predicted taken, zero=1 -> falls through
        set_in(0, 0, 32'h0, 1, 2'd3, 2'd1, 1, 0, 0, 0);
        step_pre(); chk("D sel", pc_sel, 3); chk("D fd", flush_id_ex, 1); step_post();
        // E: ID at 0x48 -> index 2^2=0, counter back to WNT
        set_in(1, 1, 32'h48, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre(); chk("E mis", mispred_cnt, 2); chk("E pred", pred_taken, 0); step_post();
        // F: mispredict again -> bht[0]=WT, ghr=0101
        set_in(0, 0, 32'h0, 1, 2'd3, 2'd0, 1, 0, 0, 0);
        step_pre(); chk("F sel", pc_sel, 2); step_post();
        // G: JALR in EX while ID (0x14, index 5^5=0) predicts taken
        set_in(1, 1, 32'h14, 1, 2'd2, 2'd0, 0, 0, 0, 0);
        step_pre(); chk("G pred", pred_taken, 1); chk("G sel", pc_sel, 2);
        chk("G fi", flush_if_id, 1); chk("G fd", flush_id_ex, 1); step_post();
        // H: GHR/BHT untouched by the jump, same branch still predicted taken
        set_in(1, 1, 32'h14, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre(); chk("H br_cnt", br_cnt, 3); chk("H pred", pred_taken, 1); chk("H sel", pc_sel, 1); step_post();
        // I: BLT sign=1 resolving while stalled
        set_in(1, 1, 32'h14, 1, 2'd3, 2'd2, 0, 1, 1, 0);
        step_pre(); chk("I sel", pc_sel, 0); chk("I fi", flush_if_id, 0); chk("I pred", pred_taken, 1); step_post();
        // J: stall drops; ID reads old GHR (index 0), update lands at the edge
        set_in(1, 1, 32'h14, 1, 2'd3, 2'd2, 0, 1, 0, 0);
        step_pre(); chk("J br_cnt", br_cnt, 3); chk("J pred", pred_taken, 1); chk("J sel", pc_sel, 1); step_post();
        set_in(0, 0, 32'h14, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre(); chk("K br_cnt", br_cnt, 4); chk("K mis", mispred_cnt, 3); step_post();

        // Drive mispredicts until the counter saturates
        for (int n = 0; n < 600 && m_mis < CMAX; n++) begin
            set_in(1, 1, $urandom & 32'hFC, 0, 2'd0, 2'd0, 0, 0, 0, 0);
            step_pre(); step_post();
            set_in(0, 0, 32'h0, 1, 2'd3, 2'd0, (m_pred == 0), 0, 0, 0);
            step_pre(); step_post();
        end
        chk("sat mis", mispred_cnt, CMAX);
        set_in(1, 1, 32'h40, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre(); step_post();
        set_in(0, 0, 32'h0, 1, 2'd3, 2'd0, (m_pred == 0), 0, 0, 0);
        step_pre(); step_post();
        chk("sat hold mis", mispred_cnt, CMAX);
        chk("sat hold br", br_cnt, CMAX);
        // perf_clr with a same-cycle mispredict
        set_in(1, 1, 32'h40, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        step_pre(); step_post();
        set_in(0, 0, 32'h0, 1, 2'd3, 2'd0, (m_pred == 0), 0, 0, 1);
        step_pre(); step_post();
        chk("clr br", br_cnt, 0);
        chk("clr mis", mispred_cnt, 0);

        // Randomized traffic, with a reset pulse mid-run
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] jt;
            rst_n = !(c == 1500 || c == 1501);
            jt = (m_br == 1 && $urandom_range(0, 3) != 0) ? 2'd3 : 2'($urandom);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom & 32'hFF, $urandom_range(0, 3) != 0, jt, 2'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 63) == 0);
            step_pre();
            step_post();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
